// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU and the two-requester ALU arbiter.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD = 4'b0000;
  localparam alu_op_t OP_SUB = 4'b0001;
  localparam alu_op_t OP_AND = 4'b0010;
  localparam alu_op_t OP_OR  = 4'b0011;
  localparam alu_op_t OP_XOR = 4'b0100;
  localparam alu_op_t OP_SHL = 4'b1000;

  // FULL means the result register holds an undelivered result.
  typedef enum logic {EMPTY, FULL} arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and monitor bundle between the two datapath masters and alu_arbiter.
// Handshakes: a transfer happens on a cycle where valid && ready are both high at the rising
// clock edge; a source holds valid and payload stable until it sees ready.
interface alu_arbiter_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    import alu_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [N-1:0]    req0_in0;
    logic [N-1:0]    req0_in1;
    alu_op_t         req0_op;

    logic            req1_valid;
    logic            req1_ready;
    logic [N-1:0]    req1_in0;
    logic [N-1:0]    req1_in1;
    alu_op_t         req1_op;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [N-1:0]    rsp_data;
    logic            rsp_id;

    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    arb_state_t      dbg_state;
    logic            dbg_prio;

    modport slave (
        input  req0_valid, req0_in0, req0_in1, req0_op,
        input  req1_valid, req1_in0, req1_in1, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output grant_cnt0, grant_cnt1,
        output dbg_state, dbg_prio
    );

    modport master (
        output req0_valid, req0_in0, req0_in1, req0_op,
        output req1_valid, req1_in0, req1_in1, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  grant_cnt0, grant_cnt1,
        input  dbg_state, dbg_prio
    );

endinterface

// File: rtl/alu.sv
// Combinational N-bit ALU; unknown opcodes produce zero, shifts of N or more produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  alu_op_t      op,
    output logic [N-1:0] out
);

    always_comb begin
        out = '0;
        case (op)
            OP_ADD:  out = in0 + in1;
            OP_SUB:  out = in0 - in1;
            OP_AND:  out = in0 & in1;
            OP_OR:   out = in0 | in1;
            OP_XOR:  out = in0 ^ in1;
            OP_SHL:  out = in0 << in1;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a single-entry tagged result
// register and saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic             prio_q;
    logic [N-1:0]     data_q;
    logic             id_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    logic             can_accept;
    logic             grant0, grant1, any_grant;
    logic [N-1:0]     alu_in0, alu_in1, alu_out;
    alu_op_t          alu_op;

    // Grants are suppressed during reset so no handshake completes against state being cleared.
    assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
    assign grant0     = !rst && can_accept && bus.req0_valid && (!bus.req1_valid || !prio_q);
    assign grant1     = !rst && can_accept && bus.req1_valid && (!bus.req0_valid ||  prio_q);
    assign any_grant  = grant0 || grant1;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        alu_in0 = '0;
        alu_in1 = '0;
        alu_op  = OP_ADD;
        if (grant1) begin
            alu_in0 = bus.req1_in0;
            alu_in1 = bus.req1_in1;
            alu_op  = bus.req1_op;
        end else if (grant0) begin
            alu_in0 = bus.req0_in0;
            alu_in1 = bus.req0_in1;
            alu_op  = bus.req0_op;
        end
    end

    alu #(.N(N)) u_alu (
        .in0 (alu_in0),
        .in1 (alu_in1),
        .op  (alu_op),
        .out (alu_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (any_grant) state_d = FULL;
            FULL:    if (bus.rsp_ready && !any_grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (any_grant) begin
                data_q <= alu_out;
                id_q   <= grant1;
                prio_q <= grant0;
            end
            if (grant0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
            if (grant1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_id     = id_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_prio   = prio_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic, all checked
// against a cycle-level reference model of the arbitration rules and the ALU arithmetic.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N     = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

    alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard / model state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [N:0]   exp_q[$];        // {id, data} of the undelivered result, at most one entry
    int           m_prio;
    int           m_cnt0, m_cnt1;
    logic [N-1:0] last_data;
    int           last_id;
    bit           got_r0, got_r1;  // DUT readies seen in the last cycle
    bit           last_g0, last_g1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] alu_ref(input alu_op_t op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        int unsigned r;
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            OP_ADD:  r = ua + ub;
            OP_SUB:  r = ua - ub;
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            OP_SHL:  r = (ub >= N) ? 0 : (ua << ub);
            default: r = 0;
        endcase
        return r[N-1:0];
    endfunction

    function automatic alu_op_t pick_op();
        alu_op_t ops[6];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL};
        if ($urandom_range(0, 7) == 0) return alu_op_t'($urandom_range(0, 15));
        return ops[$urandom_range(0, 5)];
    endfunction

    // One clock cycle: inputs are already driven (at the falling edge).
    task automatic cycle();
        bit           ca, g0, g1, drain;
        logic [N-1:0] new_data;
        logic [N:0]   popped;
        #1;
        ca = (exp_q.size() == 0) || bus.rsp_ready;
        g0 = !rst && ca && bus.req0_valid && (!bus.req1_valid || m_prio == 0);
        g1 = !rst && ca && bus.req1_valid && (!bus.req0_valid || m_prio == 1);
        check("req0_ready", bus.req0_ready, g0);
        check("req1_ready", bus.req1_ready, g1);
        got_r0  = bus.req0_ready;
        got_r1  = bus.req1_ready;
        last_g0 = g0;
        last_g1 = g1;
        drain = !rst && (exp_q.size() != 0) && bus.rsp_ready;
        if (drain) begin
            popped = exp_q.pop_front();
            check("sb_rsp_data", bus.rsp_data, popped[N-1:0]);
            check("sb_rsp_id", bus.rsp_id, popped[N]);
        end
        new_data = g1 ? alu_ref(bus.req1_op, bus.req1_in0, bus.req1_in1)
                      : alu_ref(bus.req0_op, bus.req0_in0, bus.req0_in1);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_prio = 0; m_cnt0 = 0; m_cnt1 = 0; last_data = '0; last_id = 0;
        end else if (g0 || g1) begin
            exp_q.push_back({g1, new_data});
            last_data = new_data;
            last_id   = g1 ? 1 : 0;
            m_prio    = g0 ? 1 : 0;
            if (g0 && m_cnt0 < CMAX) m_cnt0++;
            if (g1 && m_cnt1 < CMAX) m_cnt1++;
        end
        @(negedge clk);
        check("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
        check("rsp_data", bus.rsp_data, last_data);
        check("rsp_id", bus.rsp_id, last_id);
        check("grant_cnt0", bus.grant_cnt0, m_cnt0);
        check("grant_cnt1", bus.grant_cnt1, m_cnt1);
        check("prio", bus.dbg_prio, m_prio);
        check("state", 32'(bus.dbg_state), (exp_q.size() != 0) ? 32'(FULL) : 32'(EMPTY));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req0(input bit v, input alu_op_t op, input logic [N-1:0] a,
                              input logic [N-1:0] b);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_in0 = a; bus.req0_in1 = b;
    endtask

    task automatic drive_req1(input bit v, input alu_op_t op, input logic [N-1:0] a,
                              input logic [N-1:0] b);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_in0 = a; bus.req1_in1 = b;
    endtask

    initial begin
        int exp_cnt[5];
        m_prio = 0; m_cnt0 = 0; m_cnt1 = 0; last_data = '0; last_id = 0;
        got_r0 = 0; got_r1 = 0; last_g0 = 0; last_g1 = 0;

        // Reset with both requesters valid
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req0(1'b1, OP_ADD, 8'h11, 8'h22);
        drive_req1(1'b1, OP_SUB, 8'h33, 8'h01);
        @(negedge clk);
        repeat (2) begin
            cycle();
            check("t1_ready0", got_r0, 1'b0);
            check("t1_ready1", got_r1, 1'b0);
        end
        check("t1_rsp_valid", bus.rsp_valid, 1'b0);
        check("t1_rsp_data", bus.rsp_data, 8'h00);
        check("t1_cnt0", bus.grant_cnt0, 0);
        check("t1_cnt1", bus.grant_cnt1, 0);

        // Single requester
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req0(1'b1, OP_ADD, 8'h94, 8'h18);
        drive_req1(1'b0, OP_ADD, 8'h00, 8'h00);
        cycle();
        check("t2_ready0", got_r0, 1'b1);
        check("t2_rsp_valid", bus.rsp_valid, 1'b1);
        check("t2_rsp_data", bus.rsp_data, 8'hAC);
        check("t2_rsp_id", bus.rsp_id, 1'b0);
        check("t2_cnt0", bus.grant_cnt0, 1);

        // Back-pressure with req1 waiting
        drive_req0(1'b0, OP_ADD, 8'h00, 8'h00);
        drive_req1(1'b1, OP_ADD, 8'h03, 8'h04);
        bus.rsp_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("t4_ready1_held", got_r1, 1'b0);
            check("t4_rsp_data_held", bus.rsp_data, 8'hAC);
            check("t4_rsp_valid_held", bus.rsp_valid, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("t4_ready1_release", got_r1, 1'b1);
        check("t4_rsp_data", bus.rsp_data, 8'h07);
        check("t4_rsp_id", bus.rsp_id, 1'b1);

        // Contention: alternate 0,1,0,1
        drive_req0(1'b1, OP_ADD, 8'h01, 8'h01);
        drive_req1(1'b1, OP_ADD, 8'h02, 8'h02);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_rsp_id", bus.rsp_id, i % 2);
            check("t3_rsp_data", bus.rsp_data, (i % 2) ? 8'h04 : 8'h02);
        end

        // Saturation of grant_cnt0
        rst = 1'b1;
        drive_req0(1'b0, OP_ADD, 8'h00, 8'h00);
        drive_req1(1'b0, OP_ADD, 8'h00, 8'h00);
        cycle();
        rst = 1'b0;
        exp_cnt = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            drive_req0(1'b1, OP_XOR, N'($urandom), N'($urandom));
            cycle();
            check("t5_cnt0", bus.grant_cnt0, exp_cnt[i]);
        end

        // Reset while a result is stalled
        drive_req0(1'b1, OP_OR, 8'h50, 8'h05);
        bus.rsp_ready = 1'b0;
        cycle();
        cycle();
        check("t6_pre_valid", bus.rsp_valid, 1'b1);
        rst = 1'b1;
        drive_req0(1'b0, OP_ADD, 8'h00, 8'h00);
        cycle();
        check("t6_rsp_valid", bus.rsp_valid, 1'b0);
        check("t6_prio", bus.dbg_prio, 1'b0);
        check("t6_cnt0", bus.grant_cnt0, 0);
        check("t6_cnt1", bus.grant_cnt1, 0);
        rst = 1'b0;

        // Randomized traffic; requesters hold valid/payload until accepted
        for (int i = 0; i < 600; i++) begin
            if (!bus.req0_valid || last_g0)
                drive_req0($urandom_range(0, 3) != 0, pick_op(), N'($urandom), N'($urandom_range(0, 9)));
            if (!bus.req1_valid || last_g1)
                drive_req1($urandom_range(0, 3) != 0, pick_op(), N'($urandom), N'($urandom_range(0, 9)));
            bus.rsp_ready = $urandom_range(0, 2) != 0;
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
